// File: rtl/flexicore4_pkg.sv
// Shared types, register map and instruction decode for the flexicore4 accumulator core.
package flexicore4_pkg;

   typedef logic [3:0] data_t;
   typedef logic [6:0] pc_t;
   typedef logic [7:0] instr_t;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      NAND = 2'b01,
      XOR  = 2'b10,
      LD   = 2'b11
   } alu_op_e;

   localparam logic [2:0] REG_IPORT = 3'd0;
   localparam logic [2:0] REG_OPORT = 3'd1;

   typedef struct packed {
      logic       brn;
      logic       alu;
      logic       imm;
      logic       st;
      alu_op_e    op;
      logic [2:0] r;
   } dec_t;

   // Opcode classes are mutually exclusive; anything with bit3 set in the 00 class
   // but a nonzero op field falls through as a NOP.
   function automatic dec_t decode(input instr_t i);
      dec_t d;
      d     = '0;
      d.op  = alu_op_e'(i[5:4]);
      d.r   = i[2:0];
      if (i[7])
         d.brn = 1'b1;
      else if (i[6]) begin
         d.alu = 1'b1;
         d.imm = 1'b1;
      end
      else if (!i[3])
         d.alu = 1'b1;
      else if (i[5:4] == 2'b00)
         d.st = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/flexicore4_alu.sv
// Combinational 4-bit ALU: ADD (carry dropped), NAND, XOR and pass-through load.
module flexicore4_alu
   import flexicore4_pkg::*;
(
   input  logic [3:0] acc,
   input  logic [3:0] x,
   input  logic [1:0] op,
   output logic [3:0] result
);

   always_comb begin
      result = x;
      case (alu_op_e'(op))
         ADD:  result = acc + x;
         NAND: result = ~(acc & x);
         XOR:  result = acc ^ x;
         LD:   result = x;
         default: result = x;
      endcase
   end

endmodule

// File: rtl/flexicore4_core.sv
// Single-cycle 4-bit accumulator core: decode, PC sequencing and r1..r7 register file.
module flexicore4_core
   import flexicore4_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [3:0] IPORT,
   output logic [3:0] OPORT,
   output logic [6:0] PC,
   input  logic [7:0] INSTR
);

   dec_t  dec;
   data_t acc;
   data_t rf [2:7];
   data_t rd;
   data_t x;
   data_t alu_res;
   pc_t   pc_nxt;

   assign dec = decode(INSTR);

   // r0 is the live input port, r1 is the output latch itself
   always_comb begin
      rd = '0;
      case (dec.r)
         REG_IPORT: rd = IPORT;
         REG_OPORT: rd = OPORT;
         default:   rd = rf[dec.r];
      endcase
   end

   assign x = dec.imm ? INSTR[3:0] : rd;

   flexicore4_alu u_alu (
      .acc    (acc),
      .x      (x),
      .op     (dec.op),
      .result (alu_res)
   );

   assign pc_nxt = (dec.brn && acc[3]) ? INSTR[6:0] : pc_t'(PC + 7'd1);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         PC  <= '0;
         acc <= '0;
      end
      else begin
         PC <= pc_nxt;
         if (dec.alu)
            acc <= alu_res;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         OPORT <= '0;
      else if (dec.st && dec.r == REG_OPORT)
         OPORT <= acc;
   end

   // ST r0 has no target, so writes to it simply fall away
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 2; i <= 7; i++)
            rf[i] <= '0;
      end
      else if (dec.st) begin
         for (int i = 2; i <= 7; i++)
            if (dec.r == i[2:0])
               rf[i] <= acc;
      end
   end

endmodule

// File: tb/tb_flexicore4_core.sv
// Self-checking bench for flexicore4_core: vector table plus reset, echo-loop and async-reset sequences.
module tb_flexicore4_core;

   localparam logic [7:0] N = 8'h18;

   logic       clk;
   logic       rstn;
   logic [3:0] iport;
   logic [3:0] iport_v;
   logic       echo;
   logic [3:0] oport;
   logic [6:0] pc;
   logic [7:0] instr;
   logic [7:0] rom [128];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [0:7][7:0] prog;
      int              ncyc;
      logic [3:0]      iport;
      logic [6:0]      pc;
      logic [3:0]      op;
      string           name;
   } vec_t;

   vec_t        vecs [12];
   logic [10:0] sb_vec [$];
   logic [3:0]  sb_echo [$];

   assign iport = echo ? 4'(oport + 4'd1) : iport_v;
   assign instr = rom[pc];

   flexicore4_core dut (
      .CLK   (clk),
      .RSTN  (rstn),
      .IPORT (iport),
      .OPORT (oport),
      .PC    (pc),
      .INSTR (instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_rom(input logic [0:7][7:0] prog);
      for (int a = 0; a < 128; a++) rom[a] = N;
      for (int a = 0; a < 8; a++) rom[a] = prog[a];
   endtask

   task automatic run_vec(input vec_t v);
      logic [10:0] e;
      rstn    = 1'b0;
      echo    = 1'b0;
      fill_rom(v.prog);
      iport_v = v.iport;
      sb_vec.push_back({v.pc, v.op});
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (v.ncyc) @(posedge clk);
      @(negedge clk);
      e = sb_vec.pop_front();
      chk({v.name, "_pc"}, int'(pc), int'(e[10:4]));
      chk({v.name, "_oport"}, int'(oport), int'(e[3:0]));
   endtask

   initial begin
      logic [3:0] prev;
      int         budget;

      rstn    = 1'b0;
      echo    = 1'b0;
      iport_v = 4'h0;
      for (int a = 0; a < 128; a++) rom[a] = N;

      vecs[0]  = '{{N,N,N,N,N,N,N,N},                                   3, 4'h0, 7'd3,  4'h0, "nop_run"};
      vecs[1]  = '{{8'h75,8'h09,N,N,N,N,N,N},                           2, 4'h0, 7'd2,  4'h5, "ldi_st"};
      vecs[2]  = '{{8'h7F,8'h43,8'h09,N,N,N,N,N},                       3, 4'h0, 7'd3,  4'h2, "add_wrap"};
      vecs[3]  = '{{8'h7C,8'h5A,8'h09,N,N,N,N,N},                       3, 4'h0, 7'd3,  4'h7, "nandi"};
      vecs[4]  = '{{8'h76,8'h63,8'h09,N,N,N,N,N},                       3, 4'h0, 7'd3,  4'h5, "xori"};
      vecs[5]  = '{{8'h78,8'hC0,N,N,N,N,N,N},                           2, 4'h0, 7'h40, 4'h0, "brn_taken"};
      vecs[6]  = '{{8'h77,8'hC0,N,N,N,N,N,N},                           2, 4'h0, 7'd2,  4'h0, "brn_not"};
      vecs[7]  = '{{8'h79,8'h0B,8'h70,8'h03,8'h03,8'h09,N,N},           6, 4'h0, 7'd6,  4'h2, "reg_add"};
      vecs[8]  = '{{8'h74,8'h08,8'h30,8'h09,N,N,N,N},                   4, 4'hA, 7'd4,  4'hA, "r0_read"};
      vecs[9]  = '{{8'h73,8'h09,8'h70,8'h31,8'h41,8'h09,N,N},           6, 4'h0, 7'd6,  4'h4, "r1_read"};
      vecs[10] = '{{8'h75,8'h09,8'h72,8'h19,8'h29,8'h39,N,N},           6, 4'h0, 7'd6,  4'h5, "nops"};
      vecs[11] = '{{8'h79,8'h83,8'h71,8'h09,N,N,N,N},                   3, 4'h0, 7'd4,  4'h9, "brn_keeps_acc"};

      // reset hold, then PC counts from the first edge after release
      repeat (10) @(negedge clk);
      chk("rst_pc", int'(pc), 0);
      chk("rst_oport", int'(oport), 0);
      rstn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("rel_pc%0d", k), int'(pc), k);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // PC wraps 127 -> 0
      rstn = 1'b0;
      fill_rom({8'h78,8'hFE,N,N,N,N,N,N});
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pc_127", int'(pc), 127);
      @(posedge clk); @(negedge clk);
      chk("pc_wrap", int'(pc), 0);

      // echo loop: OPORT should step 1,2,...,15,0,1 once per 4-cycle loop
      rstn = 1'b0;
      fill_rom({8'h30,8'h09,8'h78,8'h80,N,N,N,N});
      echo = 1'b1;
      for (int v = 1; v <= 17; v++) sb_echo.push_back(4'(v));
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      prev   = oport;
      budget = 17 * 4 + 8;
      while (budget > 0 && sb_echo.size() > 0) begin
         @(negedge clk);
         budget--;
         if (oport != prev) begin
            chk("echo_step", int'(oport), int'(sb_echo.pop_front()));
            prev = oport;
         end
      end
      chk("echo_drain", sb_echo.size(), 0);
      echo = 1'b0;

      // async reset between edges, then confirm ACC and r3 were cleared too
      rstn = 1'b0;
      fill_rom({8'h75,8'h09,8'h0B,N,N,N,N,N});
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_async_oport", int'(oport), 5);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("async_pc", int'(pc), 0);
      chk("async_oport", int'(oport), 0);
      fill_rom({8'h33,8'h41,8'h09,N,N,N,N,N});
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_async_acc", int'(oport), 1);
      chk("post_async_pc", int'(pc), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
